// File: rtl/row_fetch_engine.sv
// Row fetch engine: reads one image row from frame memory into a row buffer and streams it as pixels.
// Build option ROW_FETCH_PIX_SWAP_EN: emit the most significant pixel slice of each word first.
module row_fetch_engine #(
    parameter int DATA_W       = 128,
    parameter int PIX_W        = 16,
    parameter int ROW_PIX      = 640,
    parameter int ADDR_W       = 25,
    parameter int ADDR_INC     = 4,
    parameter int FRAME_STRIDE = 'h25800,
    parameter int NUM_FRAMES   = 6,
    parameter int MAX_OUT      = 4
) (
    input  logic              clk_133M,
    input  logic              rst_133M,
    input  logic              start_frame,
    input  logic [2:0]        frame_sel,
    input  logic              start_row,
    input  logic              ram_busy,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_address,
    input  logic              rd_valid,
    input  logic [DATA_W-1:0] rd_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [PIX_W-1:0]  pix_data,
    output logic              row_done,
    output logic              overrun
);
    // state | meaning
    // IDLE  | waiting for start_row; start_frame loads the frame base address
    // FETCH | issuing read requests for the row
    // WAIT  | all requests issued, collecting remaining read data
    // DRAIN | all words stored, streaming the remaining pixels

    localparam int PPW    = DATA_W / PIX_W;
    localparam int WORDS  = ROW_PIX / PPW;
    localparam int CNT_W  = $clog2(WORDS + 1);
    localparam int SUB_W  = (PPW > 1) ? $clog2(PPW) : 1;
    localparam int PIX_CW = $clog2(ROW_PIX);

    typedef enum logic [1:0] {IDLE, FETCH, WAIT, DRAIN} state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_rd_address;
    logic [3:0]        r_outst;
    logic [CNT_W-1:0]  r_issued;
    logic [CNT_W-1:0]  r_recv;
    logic [CNT_W-1:0]  r_src_word;
    logic [SUB_W-1:0]  r_src_sub;
    logic [PIX_CW-1:0] r_out_cnt;
    logic              r_pix_valid;
    logic [PIX_W-1:0]  r_pix_data;
    logic              r_row_done;
    logic              r_overrun;
    logic [DATA_W-1:0] r_buf [WORDS];

    logic              w_rd_req;
    logic              w_rd_acc;
    logic              w_rd_drop;
    logic              w_start_drop;
    logic              w_load;
    logic              w_pix_acc;
    logic              w_last_acc;
    logic [DATA_W-1:0] w_word;
    logic [PIX_W-1:0]  w_pix;
    logic [ADDR_W-1:0] w_frame_base;

    // Request is combinational so that ram_busy blocks it in the same cycle.
    assign w_rd_req     = !rst_133M && (r_state == FETCH) && !ram_busy &&
                          (r_outst < 4'(MAX_OUT)) && (r_issued < CNT_W'(WORDS));
    assign w_rd_acc     = rd_valid && ((r_state == FETCH) || (r_state == WAIT)) && (r_outst != '0);
    assign w_rd_drop    = rd_valid && !w_rd_acc;
    assign w_start_drop = (start_row || start_frame) && (r_state != IDLE);
    assign w_pix_acc    = r_pix_valid && pix_ready;
    assign w_last_acc   = w_pix_acc && (r_out_cnt == PIX_CW'(ROW_PIX - 1));
    assign w_load       = (r_state != IDLE) && (!r_pix_valid || pix_ready) && (r_src_word < r_recv);
    assign w_word       = r_buf[r_src_word];
    assign w_frame_base = (int'(frame_sel) < NUM_FRAMES) ?
                          ADDR_W'(frame_sel) * ADDR_W'(FRAME_STRIDE) : '0;

    always_comb begin
        w_pix = '0;
        for (int k = 0; k < PPW; k++) begin
            if (r_src_sub == SUB_W'(k)) begin
`ifdef ROW_FETCH_PIX_SWAP_EN
                w_pix = w_word[(PPW-1-k)*PIX_W +: PIX_W];
`else
                w_pix = w_word[k*PIX_W +: PIX_W];
`endif
            end
        end
    end

    always_ff @(posedge clk_133M) begin
        if (!rst_133M && w_rd_acc) begin
            r_buf[r_recv] <= rd_data;
        end
    end

    always_ff @(posedge clk_133M) begin
        if (rst_133M) begin
            r_state      <= IDLE;
            r_rd_address <= '0;
            r_outst      <= '0;
            r_issued     <= '0;
            r_recv       <= '0;
            r_src_word   <= '0;
            r_src_sub    <= '0;
            r_out_cnt    <= '0;
            r_pix_valid  <= 1'b0;
            r_pix_data   <= '0;
            r_row_done   <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_row_done <= 1'b0;
            r_overrun  <= w_start_drop || w_rd_drop;

            if (w_rd_req) begin
                r_rd_address <= r_rd_address + ADDR_W'(ADDR_INC);
                r_issued     <= r_issued + 1'b1;
            end
            case ({w_rd_req, w_rd_acc})
                2'b10:   r_outst <= r_outst + 1'b1;
                2'b01:   r_outst <= r_outst - 1'b1;
                default: r_outst <= r_outst;
            endcase
            if (w_rd_acc) begin
                r_recv <= r_recv + 1'b1;
            end

            // One-entry output register: refill whenever empty or being accepted.
            if (w_load) begin
                r_pix_valid <= 1'b1;
                r_pix_data  <= w_pix;
                if (r_src_sub == SUB_W'(PPW - 1)) begin
                    r_src_sub  <= '0;
                    r_src_word <= r_src_word + 1'b1;
                end else begin
                    r_src_sub <= r_src_sub + 1'b1;
                end
            end else if (pix_ready) begin
                r_pix_valid <= 1'b0;
            end
            if (w_pix_acc) begin
                r_out_cnt <= r_out_cnt + 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (start_frame) begin
                        r_rd_address <= w_frame_base;
                    end
                    if (start_row) begin
                        r_state    <= FETCH;
                        r_issued   <= '0;
                        r_recv     <= '0;
                        r_src_word <= '0;
                        r_src_sub  <= '0;
                        r_out_cnt  <= '0;
                    end
                end
                FETCH: begin
                    if (w_rd_req && (r_issued == CNT_W'(WORDS - 1))) begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (w_rd_acc && (r_recv == CNT_W'(WORDS - 1))) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_last_acc) begin
                        r_state    <= IDLE;
                        r_row_done <= 1'b1;
                        r_out_cnt  <= '0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rd_req     = w_rd_req;
    assign rd_address = r_rd_address;
    assign pix_valid  = r_pix_valid;
    assign pix_data   = r_pix_data;
    assign row_done   = r_row_done;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_row_fetch_engine.sv
// Directed bench for row_fetch_engine: latency memory model, pixel sequence and address checks.
// Honours ROW_FETCH_PIX_SWAP_EN when computing expected pixel order.
module tb_row_fetch_engine;
    logic         clk_133M = 1'b0;
    logic         rst_133M = 1'b1;
    logic         start_frame = 1'b0;
    logic [2:0]   frame_sel = 3'd0;
    logic         start_row = 1'b0;
    logic         ram_busy = 1'b0;
    logic         rd_req;
    logic [24:0]  rd_address;
    logic         rd_valid = 1'b0;
    logic [127:0] rd_data = '0;
    logic         pix_valid;
    logic         pix_ready = 1'b1;
    logic [15:0]  pix_data;
    logic         row_done;
    logic         overrun;

    row_fetch_engine dut (
        .clk_133M    (clk_133M),
        .rst_133M    (rst_133M),
        .start_frame (start_frame),
        .frame_sel   (frame_sel),
        .start_row   (start_row),
        .ram_busy    (ram_busy),
        .rd_req      (rd_req),
        .rd_address  (rd_address),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_data    (pix_data),
        .row_done    (row_done),
        .overrun     (overrun)
    );

    always #5 clk_133M = ~clk_133M;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        int           due;
        logic [127:0] data;
    } resp_t;

    resp_t       resp_q[$];
    int          cyc = 0;
    int          lat = 3;
    bit          busy_rand = 1'b0;
    bit          hold_resp = 1'b0;
    bit          stall_en = 1'b0;
    int          stall_left = 0;
    logic [24:0] exp_addr = '0;
    logic [24:0] first_addr = '0;
    logic [24:0] last_addr = '0;
    int          reqs_row = 0;
    int          valids_row = 0;
    int          max_ahead = 0;
    int          pix_idx = 0;
    int          rowdone_cnt = 0;
    int          overrun_cnt = 0;
    bit          prev_stall = 1'b0;
    logic [15:0] prev_data = '0;
    logic [3:0]  row_tag = 4'd0;

    // Word w of a row carries pixels 8w..8w+7, slice k = pixel 8w+k, row tag in the top nibble.
    function automatic logic [127:0] make_word(int idx);
        logic [127:0] w;
        for (int k = 0; k < 8; k++) w[k*16 +: 16] = {row_tag, 12'(8*idx + k)};
        return w;
    endfunction

    function automatic logic [15:0] exp_pix(int p);
        int w;
        int k;
        w = p / 8;
        k = p % 8;
`ifdef ROW_FETCH_PIX_SWAP_EN
        k = 7 - k;
`endif
        return {row_tag, 12'(8*w + k)};
    endfunction

    // Memory model and stream monitor: drive at the falling edge, sample 1 ns before the rising edge.
    always begin
        resp_t r;
        @(negedge clk_133M);
        cyc++;
        ram_busy  = busy_rand ? ($urandom_range(0, 1) == 1) : 1'b0;
        pix_ready = 1'b1;
        if (stall_en && pix_idx == 300 && stall_left > 0) begin
            pix_ready = 1'b0;
            stall_left--;
        end
        rd_valid = 1'b0;
        if (!hold_resp && resp_q.size() > 0 && resp_q[0].due <= cyc) begin
            rd_data  = resp_q[0].data;
            rd_valid = 1'b1;
            void'(resp_q.pop_front());
            valids_row++;
        end
        #4;
        if (rd_req) begin
            check("rd_addr", rd_address, exp_addr);
            if (reqs_row == 0) first_addr = rd_address;
            last_addr = rd_address;
            exp_addr  = exp_addr + 25'd4;
            r.due  = cyc + lat;
            r.data = make_word(reqs_row);
            resp_q.push_back(r);
            reqs_row++;
            if (reqs_row - valids_row > max_ahead) max_ahead = reqs_row - valids_row;
        end
        if (prev_stall) begin
            check("pix_stable", pix_data, prev_data);
            check("pix_hold_valid", pix_valid, 1);
        end
        if (pix_valid && pix_ready) begin
            check("pix_seq", pix_data, exp_pix(pix_idx));
            pix_idx++;
        end
        if (row_done) begin
            rowdone_cnt++;
            check("row_done_at", pix_idx, 640);
        end
        if (overrun) overrun_cnt++;
        prev_stall = pix_valid && !pix_ready;
        prev_data  = pix_data;
    end

    task automatic step();
        @(negedge clk_133M);
        #1;
    endtask

    task automatic row_begin(input logic [3:0] tag);
        row_tag     = tag;
        reqs_row    = 0;
        valids_row  = 0;
        max_ahead   = 0;
        pix_idx     = 0;
        rowdone_cnt = 0;
        overrun_cnt = 0;
    endtask

    task automatic wait_row();
        for (int i = 0; i < 6000 && rowdone_cnt == 0; i++) step();
        check("row_done_seen", rowdone_cnt != 0, 1);
        repeat (4) step();
    endtask

    task automatic row_end_checks(input string tag, input logic [24:0] fa, input logic [24:0] la);
        check({tag, "_reqs"}, reqs_row, 80);
        check({tag, "_first"}, first_addr, fa);
        check({tag, "_last"}, last_addr, la);
        check({tag, "_row_done_cnt"}, rowdone_cnt, 1);
        check({tag, "_pix_cnt"}, pix_idx, 640);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_req"}, rd_req, 0);
        check({tag, "_rd_address"}, rd_address, 0);
        check({tag, "_pix_valid"}, pix_valid, 0);
        check({tag, "_pix_data"}, pix_data, 0);
        check({tag, "_row_done"}, row_done, 0);
        check({tag, "_overrun"}, overrun, 0);
    endtask

    initial begin
        int n_stale;
        int pix_snap;

        repeat (3) step();
        #3;
        check_reset_outputs("reset");
        step();
        rst_133M = 1'b0;

        // Row A: frame 2, no back-pressure; word 0 is 0007_..._0000.
        step();
        frame_sel   = 3'd2;
        start_frame = 1'b1;
        exp_addr    = 25'h4B000;
        step();
        start_frame = 1'b0;
        #3;
        check("frame2_addr", rd_address, 25'h4B000);
        step();
        row_begin(4'd0);
        start_row = 1'b1;
        step();
        start_row = 1'b0;
        wait_row();
        row_end_checks("rowA", 25'h4B000, 25'h4B13C);
        check("rowA_overrun", overrun_cnt, 0);

        // Row B: illegal slot gives base 0; long latency; dropped starts while fetching.
        step();
        frame_sel   = 3'd7;
        start_frame = 1'b1;
        exp_addr    = 25'h0;
        step();
        start_frame = 1'b0;
        #3;
        check("frame7_addr", rd_address, 25'h0);
        step();
        lat = 20;
        row_begin(4'd2);
        start_row = 1'b1;
        step();
        start_row = 1'b0;
        repeat (10) step();
        start_row = 1'b1;
        step();
        start_row = 1'b0;
        repeat (5) step();
        frame_sel   = 3'd4;
        start_frame = 1'b1;
        step();
        start_frame = 1'b0;
        wait_row();
        row_end_checks("rowB", 25'h0, 25'h13C);
        check("rowB_overrun", overrun_cnt, 2);
        check("rowB_max_outstanding", max_ahead, 4);

        // Row C: start_frame with start_row, random ram_busy, 50-cycle pixel stall.
        step();
        lat         = 5;
        busy_rand   = 1'b1;
        stall_en    = 1'b1;
        stall_left  = 50;
        frame_sel   = 3'd1;
        start_frame = 1'b1;
        start_row   = 1'b1;
        exp_addr    = 25'h25800;
        row_begin(4'd3);
        step();
        start_frame = 1'b0;
        start_row   = 1'b0;
        wait_row();
        busy_rand = 1'b0;
        stall_en  = 1'b0;
        row_end_checks("rowC", 25'h25800, 25'h2593C);
        check("rowC_overrun", overrun_cnt, 0);
        check("rowC_max_outstanding_le4", max_ahead <= 4, 1);

        // Row D: reset after 30 words; in-flight responses must only raise overrun.
        step();
        lat         = 4;
        frame_sel   = 3'd3;
        start_frame = 1'b1;
        start_row   = 1'b1;
        exp_addr    = 25'h70800;
        row_begin(4'd4);
        step();
        start_frame = 1'b0;
        start_row   = 1'b0;
        for (int i = 0; i < 2000 && valids_row < 30; i++) step();
        check("rowD_30_words", valids_row, 30);
        hold_resp = 1'b1;
        step();
        rst_133M = 1'b1;
        step();
        rst_133M    = 1'b0;
        exp_addr    = 25'h0;
        n_stale     = resp_q.size();
        reqs_row    = 0;
        overrun_cnt = 0;
        pix_snap    = pix_idx;
        #3;
        check_reset_outputs("midrow_reset");
        hold_resp = 1'b0;
        for (int i = 0; i < 200 && resp_q.size() > 0; i++) step();
        repeat (4) step();
        check("stale_overrun_pulses", overrun_cnt, n_stale);
        check("stale_no_req", reqs_row, 0);
        check("stale_no_pix", pix_idx, pix_snap);

        // Row E: plain start_row after reset resumes from address 0.
        step();
        lat = 6;
        row_begin(4'd5);
        start_row = 1'b1;
        step();
        start_row = 1'b0;
        wait_row();
        row_end_checks("rowE", 25'h0, 25'h13C);
        check("rowE_overrun", overrun_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
